xadac_scoreboard: RTL and testbench

- Tracks in-flight XADAC instructions between decode/dispatch and execute response.
- One entry per transaction ID; the number of entries is parametrised by IdWidth.
- Stalls dispatch on RAW/WAW hazards against pending scalar (rd) and vector (vd) destinations, and on ID reuse.
- Generalises the fixed 2-scalar/3-vector-source, 16-entry arrangement to arbitrary source counts, depths and register-file sizes, with retire bypass as an option.

---
 rtl/xadac_scoreboard.sv | 142 ++++++++++++++
 tb/tb_xadac_scoreboard.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/xadac_scoreboard.sv
// Tracks in-flight XADAC instructions per transaction ID; stalls dispatch on RAW/WAW register hazards and ID reuse.
// Latency: accepted dispatch is visible 1 cycle later; retire unstalls after 1 cycle (0 when XADAC_SB_BYPASS_EN is defined).
// Backpressure: disp_ready_o is combinational from state and disp_* fields (never disp_valid_i) and drops on any hazard or flush.
module xadac_scoreboard #(
    parameter int IdWidth      = 4,
    parameter int NoRs         = 2,
    parameter int NoVs         = 3,
    parameter int RegAddrWidth = 5,
    parameter int VecAddrWidth = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         disp_valid_i,
    output logic                         disp_ready_o,
    input  logic [IdWidth-1:0]           disp_id_i,
    input  logic [RegAddrWidth-1:0]      disp_rd_addr_i,
    input  logic                         disp_rd_clobber_i,
    input  logic [VecAddrWidth-1:0]      disp_vd_addr_i,
    input  logic                         disp_vd_clobber_i,
    input  logic [NoRs*RegAddrWidth-1:0] disp_rs_addr_i,
    input  logic [NoRs-1:0]              disp_rs_read_i,
    input  logic [NoVs*VecAddrWidth-1:0] disp_vs_addr_i,
    input  logic [NoVs-1:0]              disp_vs_read_i,
    input  logic                         ret_valid_i,
    input  logic [IdWidth-1:0]           ret_id_i,
    output logic [IdWidth:0]             count_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         ret_err_o
);

    localparam int SbLen   = 2 ** IdWidth;
    localparam int NumRegs = 2 ** RegAddrWidth;
    localparam int NumVecs = 2 ** VecAddrWidth;

    localparam logic [IdWidth:0] CntOne  = (IdWidth+1)'(1);
    localparam logic [IdWidth:0] CntFull = (IdWidth+1)'(SbLen);

    // Per-entry state
    logic [SbLen-1:0]        id_used_q;
    logic [SbLen-1:0]        rd_v_q;
    logic [SbLen-1:0]        vd_v_q;
    logic [RegAddrWidth-1:0] rd_addr_q [SbLen];
    logic [VecAddrWidth-1:0] vd_addr_q [SbLen];

    // Pending-destination bitmaps; each set bit has exactly one owning entry
    logic [NumRegs-1:0]      reg_pend_q;
    logic [NumVecs-1:0]      vec_pend_q;

    logic [IdWidth:0]        count_q;
    logic                    ret_err_q;

    // State as seen by the hazard check (optionally with the retiring entry removed)
    logic [SbLen-1:0]        id_used_chk;
    logic [NumRegs-1:0]      reg_pend_chk;
    logic [NumVecs-1:0]      vec_pend_chk;

    logic ret_hit;
    logic accept;
    logic rd_v_new;

    assign ret_hit  = ret_valid_i && id_used_q[ret_id_i];
    assign accept   = disp_valid_i && disp_ready_o;
    // x0 is hardwired zero, so a write to it never creates a pending destination
    assign rd_v_new = disp_rd_clobber_i && (disp_rd_addr_i != '0);

    // Hazard-check view: optionally strip the entry that is retiring this cycle
    always_comb begin
        id_used_chk  = id_used_q;
        reg_pend_chk = reg_pend_q;
        vec_pend_chk = vec_pend_q;
`ifdef XADAC_SB_BYPASS_EN
        if (ret_hit) begin
            id_used_chk[ret_id_i] = 1'b0;
            if (rd_v_q[ret_id_i]) reg_pend_chk[rd_addr_q[ret_id_i]] = 1'b0;
            if (vd_v_q[ret_id_i]) vec_pend_chk[vd_addr_q[ret_id_i]] = 1'b0;
        end
`endif
    end

    // Dispatch readiness: free ID, no RAW on any source, no WAW on any destination, no flush
    always_comb begin
        disp_ready_o = 1'b1;
        if (id_used_chk[disp_id_i]) disp_ready_o = 1'b0;
        for (int k = 0; k < NoRs; k++) begin
            if (disp_rs_read_i[k] && reg_pend_chk[disp_rs_addr_i[k*RegAddrWidth +: RegAddrWidth]])
                disp_ready_o = 1'b0;
        end
        for (int k = 0; k < NoVs; k++) begin
            if (disp_vs_read_i[k] && vec_pend_chk[disp_vs_addr_i[k*VecAddrWidth +: VecAddrWidth]])
                disp_ready_o = 1'b0;
        end
        if (disp_rd_clobber_i && reg_pend_chk[disp_rd_addr_i]) disp_ready_o = 1'b0;
        if (disp_vd_clobber_i && vec_pend_chk[disp_vd_addr_i]) disp_ready_o = 1'b0;
        if (flush_i) disp_ready_o = 1'b0;
    end

    // Entry allocation/retirement; reset and flush both wipe everything, discarding any concurrent accept or retire
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            id_used_q  <= '0;
            rd_v_q     <= '0;
            vd_v_q     <= '0;
            reg_pend_q <= '0;
            vec_pend_q <= '0;
            count_q    <= '0;
            ret_err_q  <= 1'b0;
            for (int i = 0; i < SbLen; i++) begin
                rd_addr_q[i] <= '0;
                vd_addr_q[i] <= '0;
            end
        end else begin
            ret_err_q <= ret_valid_i && !id_used_q[ret_id_i];
            // Retire first so that a same-ID re-dispatch (bypass build) overwrites the entry
            if (ret_hit) begin
                id_used_q[ret_id_i] <= 1'b0;
                rd_v_q[ret_id_i]    <= 1'b0;
                vd_v_q[ret_id_i]    <= 1'b0;
                if (rd_v_q[ret_id_i]) reg_pend_q[rd_addr_q[ret_id_i]] <= 1'b0;
                if (vd_v_q[ret_id_i]) vec_pend_q[vd_addr_q[ret_id_i]] <= 1'b0;
            end
            if (accept) begin
                id_used_q[disp_id_i] <= 1'b1;
                rd_v_q[disp_id_i]    <= rd_v_new;
                vd_v_q[disp_id_i]    <= disp_vd_clobber_i;
                rd_addr_q[disp_id_i] <= disp_rd_addr_i;
                vd_addr_q[disp_id_i] <= disp_vd_addr_i;
                if (rd_v_new)          reg_pend_q[disp_rd_addr_i] <= 1'b1;
                if (disp_vd_clobber_i) vec_pend_q[disp_vd_addr_i] <= 1'b1;
            end
            if (accept && !ret_hit)      count_q <= count_q + CntOne;
            else if (!accept && ret_hit) count_q <= count_q - CntOne;
        end
    end

    assign count_o   = count_q;
    assign full_o    = (count_q == CntFull);
    assign empty_o   = (count_q == '0);
    assign ret_err_o = ret_err_q;

endmodule

// File: tb/tb_xadac_scoreboard.sv
// Directed bench for xadac_scoreboard: expected counters/flags queued per step and checked after each edge.
// Latency: checks occur 1 time unit after each rising edge; readiness is checked combinationally mid-cycle.
// Backpressure: stalls are provoked by RAW/WAW/ID-reuse/flush and their release is timed per build (XADAC_SB_BYPASS_EN).
module tb_xadac_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i;
    logic        disp_valid_i;
    logic        disp_ready_o;
    logic [3:0]  disp_id_i;
    logic [4:0]  disp_rd_addr_i;
    logic        disp_rd_clobber_i;
    logic [4:0]  disp_vd_addr_i;
    logic        disp_vd_clobber_i;
    logic [9:0]  disp_rs_addr_i;
    logic [1:0]  disp_rs_read_i;
    logic [14:0] disp_vs_addr_i;
    logic [2:0]  disp_vs_read_i;
    logic        ret_valid_i;
    logic [3:0]  ret_id_i;
    logic [4:0]  count_o;
    logic        full_o;
    logic        empty_o;
    logic        ret_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    int    q_cnt[$];
    bit    q_err[$];
    string q_tag[$];

    xadac_scoreboard dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o), .disp_id_i(disp_id_i),
        .disp_rd_addr_i(disp_rd_addr_i), .disp_rd_clobber_i(disp_rd_clobber_i),
        .disp_vd_addr_i(disp_vd_addr_i), .disp_vd_clobber_i(disp_vd_clobber_i),
        .disp_rs_addr_i(disp_rs_addr_i), .disp_rs_read_i(disp_rs_read_i),
        .disp_vs_addr_i(disp_vs_addr_i), .disp_vs_read_i(disp_vs_read_i),
        .ret_valid_i(ret_valid_i), .ret_id_i(ret_id_i),
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o), .ret_err_o(ret_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush_i = 0; disp_valid_i = 0; disp_id_i = 0;
        disp_rd_addr_i = 0; disp_rd_clobber_i = 0; disp_vd_addr_i = 0; disp_vd_clobber_i = 0;
        disp_rs_addr_i = 0; disp_rs_read_i = 0; disp_vs_addr_i = 0; disp_vs_read_i = 0;
        ret_valid_i = 0; ret_id_i = 0;
    endtask

    task automatic disp(input int id, input int rd, input bit rdc, input int vd, input bit vdc);
        disp_valid_i = 1; disp_id_i = 4'(id);
        disp_rd_addr_i = 5'(rd); disp_rd_clobber_i = rdc;
        disp_vd_addr_i = 5'(vd); disp_vd_clobber_i = vdc;
        disp_rs_read_i = 0; disp_vs_read_i = 0;
    endtask

    task automatic retire(input int id);
        ret_valid_i = 1; ret_id_i = 4'(id);
    endtask

    // Scoreboard push: state expected right after the next edge
    task automatic expect_state(input string tag, input int cnt, input bit err);
        q_tag.push_back(tag); q_cnt.push_back(cnt); q_err.push_back(err);
    endtask

    task automatic ready_is(input string tag, input bit exp);
        #1;
        chk({tag, "_ready"}, 32'(disp_ready_o), 32'(exp));
    endtask

    // Advance one edge, then pop and compare every queued expectation
    task automatic tick();
        string t;
        int    c;
        bit    e;
        @(posedge clk_i);
        #1;
        while (q_cnt.size() > 0) begin
            t = q_tag.pop_front(); c = q_cnt.pop_front(); e = q_err.pop_front();
            chk({t, "_count"}, 32'(count_o), 32'(c));
            chk({t, "_full"},  32'(full_o),  32'(c == 16));
            chk({t, "_empty"}, 32'(empty_o), 32'(c == 0));
            chk({t, "_err"},   32'(ret_err_o), 32'(e));
        end
    endtask

    initial begin
        idle();
        // Reset
        rst_ni = 0;
        expect_state("reset", 0, 0); tick();
        rst_ni = 1;
        disp(3, 5, 1, 0, 0); disp_valid_i = 0;
        ready_is("reset_idle", 1);

        // RAW on x5
        disp(3, 5, 1, 0, 0);
        ready_is("d3", 1);
        expect_state("d3", 1, 0); tick();
        idle();
        disp(4, 0, 0, 0, 0); disp_rs_read_i = 2'b10; disp_rs_addr_i = {5'd5, 5'd0};
        ready_is("raw_stall", 0);
        retire(3);
`ifdef XADAC_SB_BYPASS_EN
        ready_is("raw_bypass", 1);
        expect_state("raw_ret_acc", 1, 0); tick();
`else
        ready_is("raw_pre_retire", 0);
        expect_state("raw_ret", 0, 0); tick();
        ret_valid_i = 0;
        ready_is("raw_unstall", 1);
        expect_state("raw_acc", 1, 0); tick();
`endif
        idle(); retire(4);
        expect_state("ret4", 0, 0); tick();

        // WAW on v7
        idle(); disp(1, 0, 0, 7, 1);
        expect_state("d1", 1, 0); tick();
        idle(); disp(2, 0, 0, 7, 1);
        ready_is("waw_stall", 0);
        expect_state("waw_hold", 1, 0); tick();
        ready_is("waw_hold", 0);
        retire(1);
`ifdef XADAC_SB_BYPASS_EN
        ready_is("waw_bypass", 1);
        expect_state("waw_ret_acc", 1, 0); tick();
`else
        ready_is("waw_pre_retire", 0);
        expect_state("waw_ret", 0, 0); tick();
        ret_valid_i = 0;
        ready_is("waw_unstall", 1);
        expect_state("waw_acc", 1, 0); tick();
`endif
        // x0 never pending
        idle(); disp(5, 0, 1, 0, 0);
        ready_is("x0_wr", 1);
        expect_state("x0_wr", 2, 0); tick();
        idle(); disp(6, 0, 1, 0, 0); disp_rs_read_i = 2'b01; disp_rs_addr_i = 10'd0;
        ready_is("x0_rd", 1);
        expect_state("x0_rd", 3, 0); tick();
        idle(); retire(2); expect_state("r2", 2, 0); tick();
        retire(5); expect_state("r5", 1, 0); tick();
        retire(6); expect_state("r6", 0, 0); tick();

        // Fill all 16 IDs
        for (int i = 0; i < 16; i++) begin
            idle(); disp(i, 0, 0, 0, 0);
            expect_state("fill", i + 1, 0); tick();
        end
        idle(); disp(10, 0, 0, 0, 0); retire(9);
        ready_is("full_id_used", 0);
        expect_state("ret9_blocked", 15, 0); tick();
        idle(); retire(9);
        expect_state("ret_unused", 15, 1); tick();
        idle();
        expect_state("err_pulse_end", 15, 0); tick();

        // Flush clears everything
        flush_i = 1; disp(9, 0, 0, 0, 0);
        ready_is("flush_blocks", 0);
        expect_state("flush_full", 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            idle(); disp(i, 10 + i, 1, i, 1);
            expect_state("five", i + 1, 0); tick();
        end
        idle(); flush_i = 1; disp(7, 20, 1, 20, 1); retire(0);
        expect_state("flush_live", 0, 0); tick();
        idle(); disp(7, 0, 0, 0, 0); disp_rs_read_i = 2'b01; disp_rs_addr_i = 10'd10;
        ready_is("flush_pend_gone", 1);
        disp_valid_i = 0;
        retire(7);
        expect_state("flush_no_id7", 0, 1); tick();

        // Vector register 0 is tracked
        idle(); disp(0, 0, 0, 0, 1);
        expect_state("v0_wr", 1, 0); tick();
        idle(); disp(1, 0, 0, 0, 0); disp_vs_read_i = 3'b100; disp_vs_addr_i = 15'd0;
        ready_is("v0_raw", 0);
        idle(); disp(2, 11, 1, 0, 0);
        expect_state("pre_rst", 2, 0); tick();

        // Mid-operation reset with a live dispatch and an invalid retire
        idle(); rst_ni = 0; disp(3, 0, 0, 0, 0); retire(9);
        expect_state("mid_rst", 0, 0); tick();
        rst_ni = 1; idle();
        disp(2, 11, 1, 0, 1); disp_vs_read_i = 3'b001; disp_rs_read_i = 2'b10;
        disp_rs_addr_i = {5'd11, 5'd0}; disp_vs_addr_i = 15'd0; disp_valid_i = 0;
        ready_is("rst_clean", 1);
        idle();
        expect_state("rst_idle", 0, 0); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
